// File: rtl/st_adapter_pkg.sv
// Shared types and helpers for the Avalon-ST channel adapter and its skid buffer.
package st_adapter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PASS = 2'd1,
        DROP = 2'd2
    } state_t;

    // Framing tag carried by every skid entry; eop sits at bit 0 of a packed entry.
    typedef struct packed {
        logic sop;
        logic eop;
    } skid_tag_t;

    localparam int TAG_W = $bits(skid_tag_t);
    localparam int SAT_W = 32;

    function automatic logic [SAT_W-1:0] satInc(input logic [SAT_W-1:0] value,
                                                input logic [SAT_W-1:0] maxValue);
        return (value >= maxValue) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/st_skid_buffer.sv
// Two-entry skid buffer with registered push-side ready; ready drops only when both entries are full.
// i_markTail sets bit 0 of the most recently pushed entry if that entry survives this cycle's pop.
module st_skid_buffer
    import st_adapter_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_pushValid,
    input  logic [W-1:0] i_pushData,
    output logic         o_pushReady,
    output logic         o_popValid,
    output logic [W-1:0] o_popData,
    input  logic         i_popReady,
    input  logic         i_markTail
);

    logic [W-1:0] r_mem [2];
    logic         r_wrPtr;
    logic         r_rdPtr;
    logic [1:0]   r_count;
    logic         r_pushReady;

    logic         w_push;
    logic         w_pop;
    logic         w_tailStays;
    logic         w_tailPtr;
    logic [1:0]   w_countNext;

    assign w_push      = i_pushValid && r_pushReady;
    assign w_pop       = (r_count != 2'd0) && i_popReady;
    assign w_tailPtr   = ~r_wrPtr;
    assign w_tailStays = (r_count == 2'd2) || ((r_count == 2'd1) && !w_pop);

    always_comb begin
        w_countNext = r_count;
        if (w_push && !w_pop) begin
            w_countNext = r_count + 2'd1;
        end else if (!w_push && w_pop) begin
            w_countNext = r_count - 2'd1;
        end
    end

    // Push and mark never collide: the tail slot is always the one behind the write pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem[0]    <= '0;
            r_mem[1]    <= '0;
            r_wrPtr     <= 1'b0;
            r_rdPtr     <= 1'b0;
            r_count     <= 2'd0;
            r_pushReady <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wrPtr] <= i_pushData;
                r_wrPtr        <= ~r_wrPtr;
            end
            if (i_markTail && w_tailStays) begin
                r_mem[w_tailPtr][0] <= 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= ~r_rdPtr;
            end
            r_count     <= w_countNext;
            r_pushReady <= (w_countNext != 2'd2);
        end
    end

    assign o_pushReady = r_pushReady;
    assign o_popValid  = (r_count != 2'd0);
    assign o_popData   = r_mem[r_rdPtr];

endmodule

// File: rtl/st_channel_adapter.sv
// Avalon-ST channel adapter: per-packet channel latch, out-of-range packet drop, 2-entry skid output.
// Defining ST_CHANNEL_ADAPTER_PKTCHK_EN adds strict framing checks and the err_count port.
module st_channel_adapter
    import st_adapter_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int IN_CHAN_W    = 1,
    parameter int OUT_CHAN_W   = 8,
    parameter int MAX_CHAN     = 1,
    parameter int USE_IN_CHAN  = 1,
    parameter int DEFAULT_CHAN = 0,
    parameter int CNT_W        = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  in_ready,
    input  logic                  in_valid,
    input  logic [DATA_W-1:0]     in_data,
    input  logic [IN_CHAN_W-1:0]  in_channel,
    input  logic                  in_startofpacket,
    input  logic                  in_endofpacket,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [DATA_W-1:0]     out_data,
    output logic [OUT_CHAN_W-1:0] out_channel,
    output logic                  out_startofpacket,
    output logic                  out_endofpacket,
    output logic [CNT_W-1:0]      drop_count
`ifdef ST_CHANNEL_ADAPTER_PKTCHK_EN
    ,
    output logic [CNT_W-1:0]      err_count
`endif
);

    localparam int CMP_W   = (IN_CHAN_W > OUT_CHAN_W) ? IN_CHAN_W : OUT_CHAN_W;
    localparam int ENTRY_W = DATA_W + OUT_CHAN_W + TAG_W;
    localparam logic [SAT_W-1:0] CNT_MAX = SAT_W'({CNT_W{1'b1}});

    if (OUT_CHAN_W < 32 && (MAX_CHAN >> OUT_CHAN_W) != 0) begin : g_badMaxChan
        $error("st_channel_adapter: MAX_CHAN does not fit in OUT_CHAN_W");
    end

    state_t                r_state;
    logic [OUT_CHAN_W-1:0] r_chan;
    logic [CNT_W-1:0]      r_dropCount;

    logic                  w_accept;
    logic                  w_decide;
    logic                  w_keep;
    logic                  w_orphan;
    logic                  w_restart;
    logic                  w_push;
    logic                  w_markTail;
    logic                  w_chanOk;
    logic [CMP_W-1:0]      w_chanWide;
    logic [OUT_CHAN_W-1:0] w_newChan;
    skid_tag_t             w_tag;
    logic [ENTRY_W-1:0]    w_pushEntry;
    logic [ENTRY_W-1:0]    w_popEntry;

    assign w_accept   = in_valid && in_ready;
    assign w_chanWide = (USE_IN_CHAN != 0) ? CMP_W'(in_channel) : CMP_W'(DEFAULT_CHAN);
    assign w_chanOk   = (w_chanWide <= CMP_W'(MAX_CHAN));
    assign w_newChan  = OUT_CHAN_W'(w_chanWide);

    // Classify each accepted beat: new packet decision, mid-packet forward, or discard.
    always_comb begin
        w_decide  = 1'b0;
        w_keep    = 1'b0;
        w_orphan  = 1'b0;
        w_restart = 1'b0;
        if (w_accept) begin
            case (r_state)
                IDLE: begin
`ifdef ST_CHANNEL_ADAPTER_PKTCHK_EN
                    if (in_startofpacket) begin
                        w_decide = 1'b1;
                    end else begin
                        w_orphan = 1'b1;
                    end
`else
                    w_decide = 1'b1;
`endif
                end
                PASS: begin
                    if (in_startofpacket) begin
                        w_decide  = 1'b1;
                        w_restart = 1'b1;
                    end else begin
                        w_keep = 1'b1;
                    end
                end
                DROP: begin
                    if (in_startofpacket) begin
                        w_decide  = 1'b1;
                        w_restart = 1'b1;
                    end
                end
                default: begin
                    w_decide = 1'b0;
                end
            endcase
        end
    end

    assign w_push      = (w_decide && w_chanOk) || w_keep;
    assign w_tag       = '{sop: w_decide, eop: in_endofpacket};
    assign w_pushEntry = {in_data, (w_decide ? w_newChan : r_chan), w_tag};

`ifdef ST_CHANNEL_ADAPTER_PKTCHK_EN
    assign w_markTail = w_restart && (r_state == PASS);
`else
    assign w_markTail = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_chan      <= '0;
            r_dropCount <= '0;
        end else if (w_accept) begin
            if (w_decide) begin
                if (w_chanOk) begin
                    r_chan  <= w_newChan;
                    r_state <= in_endofpacket ? IDLE : PASS;
                end else begin
                    r_dropCount <= CNT_W'(satInc(SAT_W'(r_dropCount), CNT_MAX));
                    r_state     <= in_endofpacket ? IDLE : DROP;
                end
            end else if (in_endofpacket) begin
                r_state <= IDLE;
            end
        end
    end

`ifdef ST_CHANNEL_ADAPTER_PKTCHK_EN
    logic [CNT_W-1:0] r_errCount;

    // Orphan beats and restarts are framing errors; both can only occur on accepted beats.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_errCount <= '0;
        end else if (w_orphan || w_restart) begin
            r_errCount <= CNT_W'(satInc(SAT_W'(r_errCount), CNT_MAX));
        end
    end

    assign err_count = r_errCount;
`endif

    st_skid_buffer #(
        .W(ENTRY_W)
    ) u_skid (
        .clk        (clk),
        .reset      (reset),
        .i_pushValid(w_push),
        .i_pushData (w_pushEntry),
        .o_pushReady(in_ready),
        .o_popValid (out_valid),
        .o_popData  (w_popEntry),
        .i_popReady (out_ready),
        .i_markTail (w_markTail)
    );

    assign out_data          = w_popEntry[ENTRY_W-1 -: DATA_W];
    assign out_channel       = w_popEntry[TAG_W +: OUT_CHAN_W];
    assign out_startofpacket = w_popEntry[1];
    assign out_endofpacket   = w_popEntry[0];
    assign drop_count        = r_dropCount;

endmodule
